// File: rtl/xosera_pkg.sv
// Shared copper definitions: instruction type, COP_END encoding and fetch buffer sizing.
package xv;

  typedef logic [31:0] copper_instr_t;

  localparam copper_instr_t COP_END_INSTR   = 32'h0000_0003;
  localparam int unsigned   COP_INFO_WORDS  = 16;
  localparam int unsigned   FETCH_BUF_DEPTH = 2;

  typedef enum logic {
    StRun,
    StHalt
  } fetch_state_e;

  // Even half carries the upper 16 bits of the instruction.
  function automatic copper_instr_t join_halves(input logic [15:0] even, input logic [15:0] odd);
    return {even, odd};
  endfunction

endpackage

// File: rtl/copper_fetch_buf.sv
// Small FIFO of fetched copper instructions tagged with their fetch address.
// Supports push and pop in the same cycle; flush empties it without touching storage.
module copper_fetch_buf
  import xv::*;
#(
  parameter int unsigned AWIDTH = 10,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  copper_instr_t                push_instr_i,
  input  logic [AWIDTH-1:0]            push_pc_i,
  input  logic                         pop_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         valid_o,
  output copper_instr_t                instr_o,
  output logic [AWIDTH-1:0]            pc_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PW-1:0] ptr_t;

  copper_instr_t     instr_q [DEPTH];
  logic [AWIDTH-1:0] pc_q    [DEPTH];
  ptr_t              rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign do_pop  = pop_i & (count_q != '0);
  // A full buffer can still accept a push when the head leaves in the same cycle.
  assign do_push = push_i & ((count_q < CW'(DEPTH)) | do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        instr_q[wr_ptr_q] <= push_instr_i;
        pc_q[wr_ptr_q]    <= push_pc_i;
        wr_ptr_q          <= next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign valid_o = (count_q != '0);
  assign instr_o = instr_q[rd_ptr_q];
  assign pc_o    = pc_q[rd_ptr_q];

endmodule

// File: rtl/copper_fetch.sv
// copper_fetch: read engine for the split copper program memory, streaming {even,odd} words.
// Optional define COPPER_INFO_GUARD_EN keeps the device info block from ever being read.
module copper_fetch
  import xv::*;
#(
  parameter int unsigned AWIDTH = 10
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              restart_i,
  input  logic [AWIDTH-1:0] start_addr_i,
  input  logic              jump_i,
  input  logic [AWIDTH-1:0] jump_addr_i,
  output logic [AWIDTH-1:0] mem_addr_o,
  input  logic [15:0]       mem_even_i,
  input  logic [15:0]       mem_odd_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [AWIDTH-1:0] instr_pc_o,
  input  logic              instr_ready_i,
  output logic              halted_o
);

  localparam int unsigned DEPTH = FETCH_BUF_DEPTH;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned OW    = CW + 1;
  // Buffer entries plus the BRAM output register, which keeps its data while the
  // read address is unchanged and so can park one returned word.
  localparam int unsigned SLOTS = DEPTH + 1;

  typedef logic [AWIDTH-1:0] addr_t;

  fetch_state_e  state_q, state_d;
  addr_t         pc_q, pc_d;
  addr_t         mem_addr_q, mem_addr_d;
  logic          halted_q, halted_d;

  // rd stage: address presented to the BRAM; bus stage: its data is on mem_*_i.
  logic          rd_vld_q, rd_vld_d, rd_inj_q, rd_inj_d;
  addr_t         rd_pc_q, rd_pc_d;
  logic          bus_vld_q, bus_vld_d, bus_inj_q, bus_inj_d;
  addr_t         bus_pc_q, bus_pc_d;

  logic [CW-1:0] buf_count;
  logic          buf_valid;
  copper_instr_t buf_instr;
  addr_t         buf_pc;

  logic          flush, pop, land, land_end, credit_ok, run_next, issue, inject;
  addr_t         flush_addr, issue_pc;
  copper_instr_t bus_instr;
  logic [OW-1:0] occupied;

  assign flush      = restart_i | jump_i;
  assign flush_addr = restart_i ? start_addr_i : jump_addr_i;
  assign pop        = buf_valid & instr_ready_i;
  assign issue_pc   = flush ? flush_addr : pc_q;

  assign bus_instr = bus_inj_q ? COP_END_INSTR : join_halves(mem_even_i, mem_odd_i);
  assign land      = bus_vld_q & ~flush & ((buf_count < CW'(DEPTH)) | pop);
  assign land_end  = land & (bus_instr == COP_END_INSTR);

  assign occupied  = OW'(buf_count) + OW'(rd_vld_q) + OW'(bus_vld_q);
  // A flush drops everything in flight, so the new stream always starts immediately.
  assign credit_ok = flush | (occupied < (OW'(SLOTS) + OW'(pop)));
  assign run_next  = flush | ((state_q == StRun) & ~land_end);
  assign issue     = enable_i & run_next & credit_ok;

`ifdef COPPER_INFO_GUARD_EN
  localparam addr_t INFO_BASE = addr_t'((1 << AWIDTH) - COP_INFO_WORDS);
  assign inject = (issue_pc >= INFO_BASE);
`else
  assign inject = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    halted_d   = halted_q;
    rd_vld_d   = issue;
    rd_pc_d    = issue_pc;
    rd_inj_d   = inject;
    bus_vld_d  = bus_vld_q;
    bus_pc_d   = bus_pc_q;
    bus_inj_d  = bus_inj_q;

    if (flush) begin
      state_d   = StRun;
      halted_d  = 1'b0;
      pc_d      = flush_addr;
      bus_vld_d = 1'b0;
    end else begin
      if (land_end) begin
        state_d = StHalt;
      end
      if (pop && (state_q == StHalt) && (buf_instr == COP_END_INSTR)) begin
        halted_d = 1'b1;
      end
      // An unlanded bus word waits; rd is always empty then because credit blocked issue.
      if (!bus_vld_q || land) begin
        bus_vld_d = rd_vld_q & ~land_end;
        bus_pc_d  = rd_pc_q;
        bus_inj_d = rd_inj_q;
      end
    end

    if (issue) begin
      pc_d = issue_pc + addr_t'(1);
      if (!inject) begin
        mem_addr_d = issue_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q    <= StRun;
      pc_q       <= '0;
      mem_addr_q <= '0;
      halted_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_inj_q   <= 1'b0;
      rd_pc_q    <= '0;
      bus_vld_q  <= 1'b0;
      bus_inj_q  <= 1'b0;
      bus_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      halted_q   <= halted_d;
      rd_vld_q   <= rd_vld_d;
      rd_inj_q   <= rd_inj_d;
      rd_pc_q    <= rd_pc_d;
      bus_vld_q  <= bus_vld_d;
      bus_inj_q  <= bus_inj_d;
      bus_pc_q   <= bus_pc_d;
    end
  end

  copper_fetch_buf #(
    .AWIDTH (AWIDTH),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk          (clk),
    .reset_i      (reset_i),
    .flush_i      (flush),
    .push_i       (land),
    .push_instr_i (bus_instr),
    .push_pc_i    (bus_pc_q),
    .pop_i        (pop),
    .count_o      (buf_count),
    .valid_o      (buf_valid),
    .instr_o      (buf_instr),
    .pc_o         (buf_pc)
  );

  assign mem_addr_o    = mem_addr_q;
  assign instr_valid_o = buf_valid;
  assign instr_o       = buf_instr;
  assign instr_pc_o    = buf_pc;
  assign halted_o      = halted_q;

endmodule

// File: tb/tb_copper_fetch.sv
// Bench for copper_fetch: BRAM model plus a scoreboard of expected {pc, instr} deliveries.
module tb_copper_fetch;

  localparam logic [31:0] COP_END = 32'h0000_0003;

  logic        clk = 1'b0;
  logic        reset_i, enable_i, restart_i, jump_i, instr_ready_i;
  logic [9:0]  start_addr_i, jump_addr_i, mem_addr_o, instr_pc_o;
  logic [15:0] mem_even_i, mem_odd_i;
  logic        instr_valid_o, halted_o;
  logic [31:0] instr_o;

  logic [31:0] mem [0:1023];
  logic [41:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  copper_fetch #(
    .AWIDTH (10)
  ) dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .enable_i      (enable_i),
    .restart_i     (restart_i),
    .start_addr_i  (start_addr_i),
    .jump_i        (jump_i),
    .jump_addr_i   (jump_addr_i),
    .mem_addr_o    (mem_addr_o),
    .mem_even_i    (mem_even_i),
    .mem_odd_i     (mem_odd_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .halted_o      (halted_o)
  );

  // One-clock-latency BRAM halves sharing the read address.
  always @(posedge clk) begin
    mem_even_i <= mem[mem_addr_o][31:16];
    mem_odd_i  <= mem[mem_addr_o][15:0];
  end

  function automatic logic [41:0] mk(input logic [9:0] pc);
    return {pc, mem[pc]};
  endfunction

  task automatic pulse_flush(input logic rs, input logic jp, input logic [9:0] sa,
                             input logic [9:0] ja);
    restart_i = rs; jump_i = jp; start_addr_i = sa; jump_addr_i = ja;
    @(negedge clk);
    restart_i = 1'b0; jump_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; enable_i = 1'b0; restart_i = 1'b0; jump_i = 1'b0;
    instr_ready_i = 1'b0; start_addr_i = '0; jump_addr_i = '0;
    repeat (2) @(negedge clk);
    checks++; if (mem_addr_o !== 10'h000) begin errors++; $display("FAIL reset_addr: got %h want 000", mem_addr_o); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid_o); end
    checks++; if (instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr_o); end
    checks++; if (instr_pc_o !== 10'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", instr_pc_o); end
    checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted_o); end
    reset_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (instr_valid_o !== 1'b0 || mem_addr_o !== 10'h0) begin
      errors++; $display("FAIL idle_disabled: valid %b addr %h want 0 000", instr_valid_o, mem_addr_o);
    end
  endtask

  task automatic test_restart_stream();
    logic [41:0] exp;
    exp_q.delete(); instr_ready_i = 1'b0; enable_i = 1'b1;
    pulse_flush(1'b1, 1'b0, 10'h010, 10'h000);
    checks++; if (mem_addr_o !== 10'h010) begin errors++; $display("FAIL restart_addr: got %h want 010", mem_addr_o); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL latency_e0: valid %b want 0", instr_valid_o); end
    for (int i = 0; i < 16; i++) exp_q.push_back(mk(10'h010 + 10'(i)));
    @(negedge clk);
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL latency_e1: valid %b want 0", instr_valid_o); end
    instr_ready_i = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (instr_valid_o !== 1'b1) begin
        errors++; $display("FAIL stream_gap: cycle %0d valid %b want 1", i, instr_valid_o);
      end else begin
        exp = exp_q.pop_front();
        checks++;
        if ({instr_pc_o, instr_o} !== exp) begin
          errors++; $display("FAIL stream_data: got %h/%h want %h/%h", instr_pc_o, instr_o, exp[41:32], exp[31:0]);
        end
      end
      @(negedge clk);
    end
    instr_ready_i = 1'b0;
  endtask

  task automatic test_ready_toggle();
    logic [41:0] exp, held;
    logic        stalled;
    int          got;
    exp_q.delete(); instr_ready_i = 1'b0;
    pulse_flush(1'b1, 1'b0, 10'h040, 10'h000);
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(10'h040 + 10'(i)));
    got = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      if (stalled) begin
        checks++;
        if (instr_valid_o !== 1'b1 || {instr_pc_o, instr_o} !== held) begin
          errors++; $display("FAIL stall_stable: got %b %h/%h want 1 %h/%h", instr_valid_o, instr_pc_o, instr_o, held[41:32], held[31:0]);
        end
      end
      instr_ready_i = ((cyc % 2) == 1);
      stalled = instr_valid_o && !instr_ready_i;
      held = {instr_pc_o, instr_o};
      if (instr_valid_o && instr_ready_i) begin
        exp = exp_q.pop_front(); got++;
        checks++;
        if ({instr_pc_o, instr_o} !== exp) begin
          errors++; $display("FAIL toggle_data: got %h/%h want %h/%h", instr_pc_o, instr_o, exp[41:32], exp[31:0]);
        end
      end
      @(negedge clk);
    end
    instr_ready_i = 1'b0;
    checks++; if (got !== 8) begin errors++; $display("FAIL toggle_count: got %0d want 8", got); end
  endtask

  task automatic test_jump_flush();
    logic [41:0] exp;
    int          got;
    exp_q.delete(); instr_ready_i = 1'b0;
    pulse_flush(1'b1, 1'b0, 10'h100, 10'h000);
    repeat (5) @(negedge clk);
    checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 10'h100) begin
      errors++; $display("FAIL prefill: got %b %h want 1 100", instr_valid_o, instr_pc_o);
    end
    pulse_flush(1'b0, 1'b1, 10'h000, 10'h200);
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL jump_valid: got %b want 0", instr_valid_o); end
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(10'h200 + 10'(i)));
    instr_ready_i = 1'b1; got = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      if (instr_valid_o) begin
        exp = exp_q.pop_front(); got++;
        checks++;
        if ({instr_pc_o, instr_o} !== exp) begin
          errors++; $display("FAIL jump_data: got %h/%h want %h/%h", instr_pc_o, instr_o, exp[41:32], exp[31:0]);
        end
      end
      @(negedge clk);
    end
    instr_ready_i = 1'b0;
    checks++; if (got !== 6) begin errors++; $display("FAIL jump_count: got %0d want 6", got); end
  endtask

  task automatic test_restart_jump_same();
    logic [41:0] exp;
    int          got;
    exp_q.delete(); instr_ready_i = 1'b0;
    pulse_flush(1'b1, 1'b1, 10'h080, 10'h300);
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(10'h080 + 10'(i)));
    instr_ready_i = 1'b1; got = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      if (instr_valid_o) begin
        exp = exp_q.pop_front(); got++;
        checks++;
        if ({instr_pc_o, instr_o} !== exp) begin
          errors++; $display("FAIL prio_data: got %h/%h want %h/%h", instr_pc_o, instr_o, exp[41:32], exp[31:0]);
        end
      end
      @(negedge clk);
    end
    instr_ready_i = 1'b0;
    checks++; if (got !== 4) begin errors++; $display("FAIL prio_count: got %0d want 4", got); end
  endtask

  task automatic test_cop_end();
    logic [41:0] exp;
    logic [31:0] saved;
    logic [9:0]  addr;
    int          got;
    saved = mem[5]; mem[5] = COP_END;
    exp_q.delete(); instr_ready_i = 1'b0;
    pulse_flush(1'b1, 1'b0, 10'h003, 10'h000);
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(10'h003 + 10'(i)));
    instr_ready_i = 1'b1; got = 0;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      if (instr_valid_o) begin
        checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL halted_early: got %b want 0", halted_o); end
        exp = exp_q.pop_front(); got++;
        checks++;
        if ({instr_pc_o, instr_o} !== exp) begin
          errors++; $display("FAIL end_data: got %h/%h want %h/%h", instr_pc_o, instr_o, exp[41:32], exp[31:0]);
        end
      end
      @(negedge clk);
    end
    checks++; if (got !== 3) begin errors++; $display("FAIL end_count: got %0d want 3", got); end
    checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL halted_set: got %b want 1", halted_o); end
    addr = mem_addr_o;
    repeat (5) @(negedge clk);
    checks++; if (mem_addr_o !== addr) begin errors++; $display("FAIL addr_frozen: got %h want %h", mem_addr_o, addr); end
    checks++; if (instr_valid_o !== 1'b0 || halted_o !== 1'b1) begin
      errors++; $display("FAIL halt_hold: valid %b halted %b want 0 1", instr_valid_o, halted_o);
    end
    mem[5] = saved;
    exp_q.delete();
    pulse_flush(1'b1, 1'b0, 10'h020, 10'h000);
    checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL halt_clear: got %b want 0", halted_o); end
    for (int i = 0; i < 2; i++) exp_q.push_back(mk(10'h020 + 10'(i)));
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 2; cyc++) begin
      if (instr_valid_o) begin
        exp = exp_q.pop_front(); got++;
        checks++;
        if ({instr_pc_o, instr_o} !== exp) begin
          errors++; $display("FAIL resume_data: got %h/%h want %h/%h", instr_pc_o, instr_o, exp[41:32], exp[31:0]);
        end
      end
      @(negedge clk);
    end
    instr_ready_i = 1'b0;
    checks++; if (got !== 2) begin errors++; $display("FAIL resume_count: got %0d want 2", got); end
  endtask

  task automatic test_wrap();
    logic [41:0] exp;
    int          got, n;
    exp_q.delete(); instr_ready_i = 1'b0;
    pulse_flush(1'b1, 1'b0, 10'h3FE, 10'h000);
`ifdef COPPER_INFO_GUARD_EN
    exp_q.push_back({10'h3FE, COP_END}); n = 1;
`else
    exp_q.push_back(mk(10'h3FE)); exp_q.push_back(mk(10'h3FF));
    exp_q.push_back(mk(10'h000)); exp_q.push_back(mk(10'h001)); n = 4;
`endif
    instr_ready_i = 1'b1; got = 0;
    for (int cyc = 0; cyc < 30 && got < n; cyc++) begin
`ifdef COPPER_INFO_GUARD_EN
      checks++; if (mem_addr_o >= 10'h3F0) begin errors++; $display("FAIL info_read: addr %h want < 3f0", mem_addr_o); end
`endif
      if (instr_valid_o) begin
        exp = exp_q.pop_front(); got++;
        checks++;
        if ({instr_pc_o, instr_o} !== exp) begin
          errors++; $display("FAIL wrap_data: got %h/%h want %h/%h", instr_pc_o, instr_o, exp[41:32], exp[31:0]);
        end
      end
      @(negedge clk);
    end
    checks++; if (got !== n) begin errors++; $display("FAIL wrap_count: got %0d want %0d", got, n); end
`ifdef COPPER_INFO_GUARD_EN
    checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL info_halt: got %b want 1", halted_o); end
`endif
    instr_ready_i = 1'b0;
  endtask

  task automatic test_enable_low();
    logic [41:0] exp;
    int          got;
    exp_q.delete(); instr_ready_i = 1'b0; enable_i = 1'b1;
    pulse_flush(1'b1, 1'b0, 10'h060, 10'h000);
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(10'h060 + 10'(i)));
    repeat (4) @(negedge clk);
    enable_i = 1'b0; instr_ready_i = 1'b1; got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (instr_valid_o) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL enable_extra: got %h/%h want none", instr_pc_o, instr_o);
        end else begin
          exp = exp_q.pop_front();
          if ({instr_pc_o, instr_o} !== exp) begin
            errors++; $display("FAIL enable_data: got %h/%h want %h/%h", instr_pc_o, instr_o, exp[41:32], exp[31:0]);
          end
        end
      end
      @(negedge clk);
    end
    checks++; if (got < 1 || got > 3) begin errors++; $display("FAIL enable_count: got %0d want 1..3", got); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL enable_idle: got %b want 0", instr_valid_o); end
    instr_ready_i = 1'b0; enable_i = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) begin
      logic [9:0] a10;
      a10 = 10'(a);
      mem[a] = {6'h2A, a10, 6'h15, a10};
    end
    @(negedge clk);
    test_reset();
    test_restart_stream();
    test_ready_toggle();
    test_jump_flush();
    test_restart_jump_same();
    test_cop_end();
    test_wrap();
    test_enable_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
